fp_add_arbiter: RTL
===================

# fp_add_arbiter

Round-robin arbiter sharing one pipelined floating-point add/sub unit among up to NREQ compute stages, such as clark, park, pid, inv_park and svpwm. It replaces state-indexed operand muxing, so stages that run concurrently can issue adds without colliding. The block registers the winning operands into the adder and tracks each in-flight operation with a one-hot tag pipeline. Each result is routed back to its requester exactly when the adder produces it.

## Interface
- NREQ, 4: number of requesters (2..8)
- LAT, 7: adder pipeline latency in cycles, from registered operands to valid `add_result` (≥1)
- DW, 32: operand width (IEEE-754 single)

Ports:
- sys_clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  request per requester; held high with operands stable until granted
- opa  in  NREQ*DW  operand A, requester i in bits [i*DW +: DW]
- opb  in  NREQ*DW  operand B, same packing
- isadd  in  NREQ  1 = a+b, 0 = a−b
- gnt  out  NREQ  combinational one-hot grant; the request is accepted on the rising edge where gnt[i]=1
- add_a, add_b  out  DW  registered adder operands
- add_sub  out  1  registered add/sub select to the adder
- add_result  in  DW  adder result
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse: `add_result` belongs to requester i
- rsp_data  out  DW  equals `add_result` (pass-through)
- busy  out  1  1 while any operation is in flight or being issued

## Operation
- Each cycle, at most one requester wins; `gnt` is the one-hot winner, or 0 if `req`=0.
- Round-robin: pointer `rr` (log2 NREQ bits, reset 0). Search order is rr, rr+1, …, wrapping modulo NREQ. On accept by i, rr ← (i+1) mod NREQ; with no accept, rr holds.
- On accept edge: add_a←opa[i], add_b←opb[i], add_sub←isadd[i], tag_pipe[0]←onehot(i). With no accept: tag_pipe[0]←0 and operand registers hold.
- tag_pipe is LAT+1 stages of NREQ bits, shifting every cycle. rsp_valid = tag_pipe[LAT].
- Counter `inflight` (width ≥ log2(LAT+2)) counts +1 on accept and −1 on rsp_valid≠0. Both in the same cycle leaves it unchanged. busy = (inflight≠0) | (req≠0).
- A requester may re-assert `req` with new operands the cycle after its grant. It is still subject to rotation, so it cannot win two consecutive cycles if another requester is pending.
- A requester dropping `req` without a grant is legal; nothing is issued for it.
- Reset values: gnt=0, add_a=0, add_b=0, add_sub=0, rsp_valid=0, tag_pipe=0, rr=0, inflight=0, busy=0 (with req=0).
- Reset mid-operation clears all tags. Results of in-flight ops are discarded: no rsp_valid pulse occurs for them, even though the adder still drains.

## Timing
- Accept edge at end of cycle t. add_a/add_b/add_sub are valid in cycle t+1, and rsp_valid[i] pulses in cycle t+1+LAT.
- Full throughput: one accept per cycle sustained. Responses return in accept order, one per cycle at most.
- `gnt` depends combinationally on req and rr only, not on operands.
- No back-pressure on responses; requesters must capture `rsp_data` in the pulse cycle.

## Configuration
- FPARB_FIXED_PRIO_EN: when defined, arbitration is fixed priority, with the lowest index winning. `rr` is not implemented and requester 0 can win every cycle.
- Undefined (default): round-robin as described above.
- All other behaviour is identical in both builds.

## Test plan
- Single op: rst released; req=0001, opa[0]=0x3F800000, opb[0]=0x40000000, isadd=1 (behavioural adder, LAT=7). Required: gnt=0001 in cycle 0; add_a=0x3F800000, add_sub=1 in cycle 1; rsp_valid=0001 with rsp_data=0x40400000 in cycle 8.
- Subtract: requester 2, 0x40A00000 − 0x40000000, isadd=0. Required: rsp_valid=0100, rsp_data=0x40400000 at LAT+1 after accept.
- Round-robin: req=1111 held for 8 cycles. Required: gnt sequence 0001,0010,0100,1000,0001,…, and rsp_valid mirrors the same sequence 8 cycles later. Under FPARB_FIXED_PRIO_EN, gnt=0001 every cycle.
- Back-to-back: requesters 1 and 3 each re-request immediately after grant for 6 ops. Required: strict alternation, 12 accepts in 12 cycles, inflight peaks at 8, busy falls 8 cycles after the last accept.
- Reset mid-flight: 3 ops accepted, then rst asserted for 1 cycle 2 cycles later. Required: no rsp_valid pulse ever appears, rr=0, inflight=0, busy=0 the cycle after reset.
- Idle gaps: req pulses in cycles 0, 3, 4. Required: rsp_valid only in cycles 8, 11, 12, and rr unchanged in non-accept cycles.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//   Shares one pipelined floating-point add/sub unit among NREQ requesters.
//   One requester wins per cycle; its operands are registered into the adder
//   and a one-hot tag rides a LAT+1 deep shift register so the result can be
//   routed back to the owner in exactly the cycle the adder produces it.
//
//   Build option: define FPARB_FIXED_PRIO_EN for fixed priority arbitration
//   (lowest index wins, no rotation pointer). Default is round-robin.
//
// Ports
//   i_sys_clk     system clock
//   i_rst         synchronous active-high reset
//   i_req         per-requester request, held with stable operands until granted
//   i_opa/i_opb   operands, requester i in bits [i*DW +: DW]
//   i_isadd       per-requester op select, 1 = a+b, 0 = a-b
//   o_gnt         combinational one-hot grant (accepted on the next rising edge)
//   o_add_a/b     registered adder operands
//   o_add_sub     registered add/sub select to the adder
//   i_add_result  adder result
//   o_rsp_valid   one-hot single-cycle pulse naming the owner of i_add_result
//   o_rsp_data    pass-through of i_add_result
//   o_busy        high while any op is in flight or being requested
// ---------------------------------------------------------------------------

// Per-requester operand gate: a lane drives its bundle only when granted, so
// OR-ing all lanes forms the one-hot operand mux.
module fp_add_arbiter_lane #(
    parameter int DW = 32
) (
    input  logic          i_gnt,
    input  logic [DW-1:0] i_opa,
    input  logic [DW-1:0] i_opb,
    input  logic          i_isadd,
    output logic [2*DW:0] o_sel
);
    assign o_sel = i_gnt ? {i_opa, i_opb, i_isadd} : '0;
endmodule

module fp_add_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 7,
    parameter int DW   = 32
) (
    input  logic               i_sys_clk,
    input  logic               i_rst,
    input  logic [NREQ-1:0]    i_req,
    input  logic [NREQ*DW-1:0] i_opa,
    input  logic [NREQ*DW-1:0] i_opb,
    input  logic [NREQ-1:0]    i_isadd,
    output logic [NREQ-1:0]    o_gnt,
    output logic [DW-1:0]      o_add_a,
    output logic [DW-1:0]      o_add_b,
    output logic               o_add_sub,
    input  logic [DW-1:0]      i_add_result,
    output logic [NREQ-1:0]    o_rsp_valid,
    output logic [DW-1:0]      o_rsp_data,
    output logic               o_busy
);
    localparam int OPW = 2*DW + 1;
    localparam int IFW = $clog2(LAT + 2);

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          add;
    } op_t;

    logic [NREQ-1:0]           w_gnt;
    logic                      w_accept;
    logic [NREQ-1:0][OPW-1:0]  w_lane_sel;
    logic [OPW-1:0]            w_sel_vec;
    op_t                       w_sel;
    logic                      w_rsp_any;

    logic [DW-1:0]             r_add_a;
    logic [DW-1:0]             r_add_b;
    logic                      r_add_sub;
    logic [LAT:0][NREQ-1:0]    r_vld_pipe;
    logic [IFW-1:0]            r_inflight;

    // ---------------- arbitration ----------------
`ifdef FPARB_FIXED_PRIO_EN
    always_comb begin
        w_gnt = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_gnt    = '0;
                w_gnt[i] = 1'b1;
            end
        end
    end
`else
    localparam int RRW = $clog2(NREQ);

    logic [RRW-1:0] r_rr;
    logic [RRW-1:0] w_win;
    logic           w_found;
    logic [RRW-1:0] w_rr_nxt;

    // Search starts at r_rr and wraps modulo NREQ (NREQ need not be 2^n).
    function automatic int rr_idx(input int base, input int k);
        return (base + k) % NREQ;
    endfunction

    always_comb begin
        w_gnt   = '0;
        w_win   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && i_req[rr_idx(int'(r_rr), k)]) begin
                w_gnt[rr_idx(int'(r_rr), k)] = 1'b1;
                w_win   = RRW'(rr_idx(int'(r_rr), k));
                w_found = 1'b1;
            end
        end
    end

    assign w_rr_nxt = (w_win == RRW'(NREQ-1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst)         r_rr <= '0;
        else if (w_accept) r_rr <= w_rr_nxt;
    end
`endif

    assign w_accept = |w_gnt;
    assign o_gnt    = w_gnt;

    // ---------------- operand select ----------------
    for (genvar g = 0; g < NREQ; g++) begin : g_lane
        fp_add_arbiter_lane #(.DW(DW)) u_lane (
            .i_gnt   (w_gnt[g]),
            .i_opa   (i_opa[g*DW +: DW]),
            .i_opb   (i_opb[g*DW +: DW]),
            .i_isadd (i_isadd[g]),
            .o_sel   (w_lane_sel[g])
        );
    end

    always_comb begin
        w_sel_vec = '0;
        for (int i = 0; i < NREQ; i++) w_sel_vec = w_sel_vec | w_lane_sel[i];
    end
    assign w_sel = w_sel_vec;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_add_a   <= '0;
            r_add_b   <= '0;
            r_add_sub <= 1'b0;
        end else if (w_accept) begin
            r_add_a   <= w_sel.a;
            r_add_b   <= w_sel.b;
            r_add_sub <= w_sel.add;
        end
    end

    // ---------------- tag pipeline ----------------
    // Stage 0 is loaded alongside the operand registers, so stage LAT lines up
    // with the adder output LAT cycles after the operands are presented.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) r_vld_pipe <= '0;
        else       r_vld_pipe <= {r_vld_pipe[LAT-1:0], w_gnt};
    end

    assign w_rsp_any = |r_vld_pipe[LAT];

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_inflight <= '0;
        end else if (w_accept && !w_rsp_any) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_accept && w_rsp_any) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    assign o_add_a     = r_add_a;
    assign o_add_b     = r_add_b;
    assign o_add_sub   = r_add_sub;
    assign o_rsp_valid = r_vld_pipe[LAT];
    assign o_rsp_data  = i_add_result;
    assign o_busy      = (r_inflight != '0) | (|i_req);
endmodule
